// File: rtl/opb_register_bank_simulink2ppc_pkg.sv
// Shared types and helpers for the Simulink-to-PPC OPB register bank:
// handshake state encoding, control bit positions and register offset math.
package opb_register_bank_simulink2ppc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } opb_state_e;

    localparam int CTRL_SNAP_BIT   = 0;
    localparam int CTRL_FREEZE_BIT = 1;

    // Word offset of a byte address relative to the window base.
    function automatic logic [29:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
        return 30'((addr - base) >> 2);
    endfunction

    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [31:0] high);
        return (addr >= base) && (addr <= high);
    endfunction

    function automatic logic [29:0] ctrl_offset(input int num_ch);
        return 30'(num_ch);
    endfunction

    function automatic logic [29:0] status_offset(input int num_ch);
        return 30'(num_ch + 1);
    endfunction

endpackage

// File: rtl/opb_register_bank_simulink2ppc_if.sv
// OPB master/slave signal bundle; bit 0 is the MSB on every bus, as on OPB.
interface opb_register_bank_simulink2ppc_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [0:AW-1]   OPB_ABus;
    logic [0:DW/8-1] OPB_BE;
    logic [0:DW-1]   OPB_DBus;
    logic            OPB_RNW;
    logic            OPB_select;
    logic            OPB_seqAddr;
    logic [0:DW-1]   Sl_DBus;
    logic            Sl_xferAck;
    logic            Sl_errAck;
    logic            Sl_retry;
    logic            Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank_simulink2ppc_opb_slave_attach.sv
// OPB slave attachment: window decode, one-shot ack FSM, read-data capture
// and a registered write strobe presented to the register storage.
module opb_slave_attach
    import opb_register_bank_simulink2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h010C0500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010C05FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    opb_register_bank_simulink2ppc_if.slave bus,
    output logic [29:0]             rd_off_o,
    input  logic [C_OPB_DWIDTH-1:0] rd_data_i,
    output logic                    wr_en_o,
    output logic [29:0]             wr_off_o,
    output logic [31:0]             wr_data_o,
    output logic                    wr_be_lsb_o
);

    opb_state_e state_q, state_d;
    logic                    xfer_ack_q, xfer_ack_d;
    logic [C_OPB_DWIDTH-1:0] dbus_q, dbus_d;
    logic                    wr_en_q, wr_en_d;
    logic [29:0]             wr_off_q, wr_off_d;
    logic [31:0]             wr_data_q, wr_data_d;
    logic                    wr_be_lsb_q, wr_be_lsb_d;

    logic [C_OPB_AWIDTH-1:0] addr_s;
    logic                    in_win_s;
    logic                    unused_seq_s;

    assign addr_s       = bus.OPB_ABus;
    assign in_win_s     = in_window(32'(addr_s), C_BASEADDR, C_HIGHADDR);
    assign rd_off_o     = word_offset(32'(addr_s), C_BASEADDR);
    assign unused_seq_s = bus.OPB_seqAddr;

    // Next state; read data and write fields are captured on IDLE->ACK only
    always_comb begin
        state_d     = state_q;
        xfer_ack_d  = 1'b0;
        dbus_d      = {C_OPB_DWIDTH{1'b0}};
        wr_en_d     = 1'b0;
        wr_off_d    = wr_off_q;
        wr_data_d   = wr_data_q;
        wr_be_lsb_d = wr_be_lsb_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.OPB_select && in_win_s) begin
                    state_d     = ST_ACK;
                    xfer_ack_d  = 1'b1;
                    dbus_d      = bus.OPB_RNW ? rd_data_i : {C_OPB_DWIDTH{1'b0}};
                    wr_en_d     = ~bus.OPB_RNW;
                    wr_off_d    = rd_off_o;
                    wr_data_d   = 32'(bus.OPB_DBus);
                    wr_be_lsb_d = bus.OPB_BE[C_OPB_DWIDTH/8-1];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.OPB_select) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake registers
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q     <= ST_IDLE;
            xfer_ack_q  <= 1'b0;
            dbus_q      <= {C_OPB_DWIDTH{1'b0}};
            wr_en_q     <= 1'b0;
            wr_off_q    <= 30'h0;
            wr_data_q   <= 32'h0;
            wr_be_lsb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            xfer_ack_q  <= xfer_ack_d;
            dbus_q      <= dbus_d;
            wr_en_q     <= wr_en_d;
            wr_off_q    <= wr_off_d;
            wr_data_q   <= wr_data_d;
            wr_be_lsb_q <= wr_be_lsb_d;
        end
    end

    assign bus.Sl_DBus    = dbus_q;
    assign bus.Sl_xferAck = xfer_ack_q;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;

    assign wr_en_o     = wr_en_q;
    assign wr_off_o    = wr_off_q;
    assign wr_data_o   = wr_data_q;
    assign wr_be_lsb_o = wr_be_lsb_q;

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// Register bank exposing Simulink channel values to the PPC over OPB, with
// live/shadow copies, a snapshot trigger, a freeze selector and a snapshot counter.
module opb_register_bank_simulink2ppc
    import opb_register_bank_simulink2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h010C0500,
    parameter logic [31:0] C_HIGHADDR   = 32'h010C05FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_CH     = 4,
    parameter int          C_DATA_WIDTH = 32
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst,
    opb_register_bank_simulink2ppc_if.slave  bus,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] user_data_in,
    input  logic [C_NUM_CH-1:0]              user_valid,
    output logic [15:0]                      snap_count
);

    localparam logic [29:0] CTRL_OFF = ctrl_offset(C_NUM_CH);
    localparam logic [29:0] STAT_OFF = status_offset(C_NUM_CH);

    logic [C_DATA_WIDTH-1:0] live_q   [C_NUM_CH];
    logic [C_DATA_WIDTH-1:0] live_d   [C_NUM_CH];
    logic [C_DATA_WIDTH-1:0] shadow_q [C_NUM_CH];
    logic [C_DATA_WIDTH-1:0] shadow_d [C_NUM_CH];
    logic        freeze_q, freeze_d;
    logic        snap_req_q, snap_req_d;
    logic [15:0] snap_count_q, snap_count_d;

    logic [29:0] rd_off_s;
    logic [31:0] rd_data_s;
    logic [31:0] ch_rd_s;
    logic        wr_en_s;
    logic [29:0] wr_off_s;
    logic [31:0] wr_data_s;
    logic        wr_be_lsb_s;
    logic        ctrl_wr_s;
    logic        unused_wr_s;

    opb_slave_attach #(
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR),
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_OPB_DWIDTH (C_OPB_DWIDTH)
    ) u_attach (
        .OPB_Clk     (OPB_Clk),
        .OPB_Rst     (OPB_Rst),
        .bus         (bus),
        .rd_off_o    (rd_off_s),
        .rd_data_i   (C_OPB_DWIDTH'(rd_data_s)),
        .wr_en_o     (wr_en_s),
        .wr_off_o    (wr_off_s),
        .wr_data_o   (wr_data_s),
        .wr_be_lsb_o (wr_be_lsb_s)
    );

    assign ctrl_wr_s   = wr_en_s && (wr_off_s == CTRL_OFF) && wr_be_lsb_s;
    assign unused_wr_s = ^wr_data_s[31:2];

    // Snapshot is taken the cycle after the SNAP write; shadow sees pre-update live values
    always_comb begin
        for (int i = 0; i < C_NUM_CH; i++) begin
            live_d[i]   = user_valid[i] ? user_data_in[i*C_DATA_WIDTH +: C_DATA_WIDTH] : live_q[i];
            shadow_d[i] = snap_req_q ? live_q[i] : shadow_q[i];
        end
        freeze_d     = ctrl_wr_s ? wr_data_s[CTRL_FREEZE_BIT] : freeze_q;
        snap_req_d   = ctrl_wr_s & wr_data_s[CTRL_SNAP_BIT];
        snap_count_d = snap_req_q ? (snap_count_q + 16'd1) : snap_count_q;
    end

    // Read mux on the live address; the attach registers it into Sl_DBus
    always_comb begin
        ch_rd_s = 32'h0;
        for (int i = 0; i < C_NUM_CH; i++) begin
            ch_rd_s = ch_rd_s | ({32{rd_off_s == 30'(i)}} &
                                 32'(freeze_q ? shadow_q[i] : live_q[i]));
        end
        if (rd_off_s == CTRL_OFF) begin
            rd_data_s = 32'({31'h0, freeze_q}) << CTRL_FREEZE_BIT;
        end else if (rd_off_s == STAT_OFF) begin
            rd_data_s = {16'h0, snap_count_q};
        end else begin
            rd_data_s = ch_rd_s;
        end
    end

    // Channel, shadow and control storage
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int i = 0; i < C_NUM_CH; i++) begin
                live_q[i]   <= {C_DATA_WIDTH{1'b0}};
                shadow_q[i] <= {C_DATA_WIDTH{1'b0}};
            end
            freeze_q     <= 1'b0;
            snap_req_q   <= 1'b0;
            snap_count_q <= 16'h0;
        end else begin
            for (int i = 0; i < C_NUM_CH; i++) begin
                live_q[i]   <= live_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            freeze_q     <= freeze_d;
            snap_req_q   <= snap_req_d;
            snap_count_q <= snap_count_d;
        end
    end

    assign snap_count = snap_count_q;

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Directed self-checking bench for opb_register_bank_simulink2ppc.
module tb_opb_register_bank_simulink2ppc;

    localparam logic [31:0] BASE = 32'h010C0500;
    localparam logic [31:0] HIGH = 32'h010C05FF;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam logic [31:0] CTRL = BASE + 32'd16;
    localparam logic [31:0] STAT = BASE + 32'd20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH*DW-1:0] user_data_in = '0;
    logic [NCH-1:0]    user_valid = '0;
    logic [15:0]       snap_count;
    int                n_checks = 0;
    int                n_errors = 0;
    logic [31:0]       rdata;
    int                acks;

    opb_register_bank_simulink2ppc_if bus_if ();

    opb_register_bank_simulink2ppc #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_NUM_CH     (NCH),
        .C_DATA_WIDTH (DW)
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .bus          (bus_if),
        .user_data_in (user_data_in),
        .user_valid   (user_valid),
        .snap_count   (snap_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus_if.OPB_select  = 1'b0;
        bus_if.OPB_ABus    = 32'h0;
        bus_if.OPB_DBus    = 32'h0;
        bus_if.OPB_BE      = 4'h0;
        bus_if.OPB_RNW     = 1'b0;
        bus_if.OPB_seqAddr = 1'b0;
    endtask

    // Hold select for 'hold' cycles, then two idle cycles; collects acks and read data
    task automatic opb_xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                            input logic [31:0] wdata, input int hold,
                            output logic [31:0] rd, output int n_ack, output logic stray);
        bus_if.OPB_ABus   = addr;
        bus_if.OPB_RNW    = rnw;
        bus_if.OPB_BE     = be;
        bus_if.OPB_DBus   = wdata;
        bus_if.OPB_select = 1'b1;
        n_ack = 0;
        rd    = 32'h0;
        stray = 1'b0;
        for (int c = 0; c < hold + 2; c++) begin
            if (c == hold) idle_bus();
            tick();
            if (bus_if.Sl_xferAck === 1'b1) begin
                n_ack++;
                rd = bus_if.Sl_DBus;
            end else if (bus_if.Sl_DBus !== 32'h0) begin
                stray = 1'b1;
            end
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        int          n;
        logic        s;
        opb_xfer(addr, 1'b1, 4'hF, 32'h0, 1, d, n, s);
        check({tag, "_ack"}, 32'(n), 32'd1);
        check({tag, "_data"}, d, exp);
        check({tag, "_dbus_idle"}, 32'(s), 32'd0);
    endtask

    task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
        logic [31:0] d;
        int          n;
        logic        s;
        opb_xfer(addr, 1'b0, be, data, 1, d, n, s);
        check({tag, "_ack"}, 32'(n), 32'd1);
    endtask

    task automatic set_ch(input int ch, input logic [31:0] val);
        user_data_in[ch*DW +: DW] = val;
        user_valid[ch]            = 1'b1;
        tick();
        user_valid[ch]            = 1'b0;
    endtask

    initial begin
        logic s;
        idle_bus();
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ack", 32'(bus_if.Sl_xferAck), 32'd0);
        check("rst_dbus", bus_if.Sl_DBus, 32'h0);
        check("rst_snap_count", 32'(snap_count), 32'd0);
        check("const_zero_resp", 32'({bus_if.Sl_errAck, bus_if.Sl_retry, bus_if.Sl_toutSup}), 32'd0);
        rst = 1'b0;
        tick();

        rd_chk("rd_off0", BASE, 32'h0);
        check("snap_count_0", 32'(snap_count), 32'd0);

        set_ch(2, 32'hDEADBEEF);
        rd_chk("live_ch2", BASE + 32'd8, 32'hDEADBEEF);

        // Snapshot + freeze, then live keeps moving underneath
        wr_chk("wr_ctrl3", CTRL, 32'h3, 4'hF);
        set_ch(2, 32'h12345678);
        rd_chk("frozen_ch2", BASE + 32'd8, 32'hDEADBEEF);
        rd_chk("status_1", STAT, 32'h1);
        check("snap_count_1", 32'(snap_count), 32'd1);
        rd_chk("ctrl_rd_freeze", CTRL, 32'h2);
        wr_chk("wr_ctrl_be_off", CTRL, 32'h0, 4'b1110);
        rd_chk("ctrl_be_ignored", CTRL, 32'h2);
        wr_chk("wr_ctrl0", CTRL, 32'h0, 4'hF);
        rd_chk("live_ch2_unfrozen", BASE + 32'd8, 32'h12345678);
        wr_chk("wr_ch2_ro", BASE + 32'd8, 32'hFFFFFFFF, 4'hF);
        rd_chk("ch2_ro_kept", BASE + 32'd8, 32'h12345678);
        wr_chk("wr_stat_ro", STAT, 32'hFFFFFFFF, 4'hF);
        rd_chk("stat_ro_kept", STAT, 32'h1);

        // SNAP capture cycle coincides with a channel-0 update 5 -> 6
        set_ch(0, 32'h5);
        bus_if.OPB_ABus = CTRL; bus_if.OPB_RNW = 1'b0; bus_if.OPB_BE = 4'hF;
        bus_if.OPB_DBus = 32'h1; bus_if.OPB_select = 1'b1;
        tick();
        check("snap_coinc_ack", 32'(bus_if.Sl_xferAck), 32'd1);
        idle_bus();
        tick();
        user_data_in[0 +: DW] = 32'h6;
        user_valid[0] = 1'b1;
        tick();
        user_valid[0] = 1'b0;
        tick();
        check("snap_count_2", 32'(snap_count), 32'd2);
        wr_chk("wr_freeze", CTRL, 32'h2, 4'hF);
        rd_chk("shadow0_pre_update", BASE, 32'h5);
        wr_chk("wr_unfreeze", CTRL, 32'h0, 4'hF);
        rd_chk("live0_post_update", BASE, 32'h6);

        // In-window hole held for 4 cycles, and out-of-window addresses
        opb_xfer(BASE + 32'd36, 1'b1, 4'hF, 32'h0, 4, rdata, acks, s);
        check("hole_one_ack", 32'(acks), 32'd1);
        check("hole_rd_zero", rdata, 32'h0);
        opb_xfer(HIGH + 32'd4, 1'b1, 4'hF, 32'h0, 4, rdata, acks, s);
        check("above_win_no_ack", 32'(acks), 32'd0);
        opb_xfer(BASE - 32'd4, 1'b0, 4'hF, 32'h3, 4, rdata, acks, s);
        check("below_win_no_ack", 32'(acks), 32'd0);
        rd_chk("below_win_no_write", CTRL, 32'h0);

        // Reset lands on the edge that samples a control write; user_valid ignored
        bus_if.OPB_ABus = CTRL; bus_if.OPB_RNW = 1'b0; bus_if.OPB_BE = 4'hF;
        bus_if.OPB_DBus = 32'h2; bus_if.OPB_select = 1'b1;
        user_data_in[1*DW +: DW] = 32'hAA;
        user_valid[1] = 1'b1;
        rst = 1'b1;
        tick();
        check("rst_mid_no_ack", 32'(bus_if.Sl_xferAck), 32'd0);
        rst = 1'b0;
        user_valid[1] = 1'b0;
        idle_bus();
        tick();
        check("rst_mid_no_ack2", 32'(bus_if.Sl_xferAck), 32'd0);
        rd_chk("rst_mid_freeze0", CTRL, 32'h0);
        rd_chk("rst_valid_ignored", BASE + 32'd4, 32'h0);
        rd_chk("rst_live0_cleared", BASE, 32'h0);
        check("rst_snap_cleared", 32'(snap_count), 32'd0);

        // Select held through reset release is served as a fresh transfer
        bus_if.OPB_ABus = CTRL; bus_if.OPB_RNW = 1'b0; bus_if.OPB_BE = 4'hF;
        bus_if.OPB_DBus = 32'h2; bus_if.OPB_select = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_served_ack", 32'(bus_if.Sl_xferAck), 32'd1);
        idle_bus();
        tick();
        tick();
        rd_chk("post_rst_freeze1", CTRL, 32'h2);
        wr_chk("post_rst_unfreeze", CTRL, 32'h0, 4'hF);

        // snap_count wrap: 65535 snapshots reach FFFF, one more wraps to 0
        for (int k = 0; k < 65535; k++) begin
            opb_xfer(CTRL, 1'b0, 4'hF, 32'h1, 1, rdata, acks, s);
        end
        check("snap_count_ffff", 32'(snap_count), 32'h0000FFFF);
        wr_chk("snap_last", CTRL, 32'h1, 4'hF);
        check("snap_count_wrap", 32'(snap_count), 32'h0);
        rd_chk("status_wrap", STAT, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
